clk_tick_gen: RTL and testbench

//  Parametrised multi-channel clock-enable generator for the stopwatch datapath.

---
 rtl/clk_tick_gen_pkg.sv | 32 +++
 rtl/tick_chan.sv | 95 +++++++++
 rtl/clk_tick_gen.sv | 71 +++++++
 tb/tb_clk_tick_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_gen_pkg.sv
// Shared constants and types for the stopwatch clock-enable generator.
package clk_tick_gen_pkg;

  // Counter width used when the generator is built at its default size.
  localparam int unsigned CNT_W_DEFAULT = 26;

  // Common divisors for a 50 MHz system clock.
  localparam int unsigned DEF_DIV_1HZ   = 50_000_000;
  localparam int unsigned DEF_DIV_100HZ = 500_000;

  // Divisor / counter value at the default width.
  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Per-cycle operating mode of one channel, in priority order:
  // clear beats run, run beats hold.
  typedef enum logic [1:0] {
    CH_HOLD  = 2'd0,
    CH_RUN   = 2'd1,
    CH_CLEAR = 2'd2
  } ch_mode_e;

  // Decode the shared controls into a channel mode.
  function automatic ch_mode_e decode_mode(input logic clear, input logic en);
    if (clear) begin
      return CH_CLEAR;
    end else if (en) begin
      return CH_RUN;
    end
    return CH_HOLD;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider channel: a counter running against an active divisor, with a
// shadow divisor that is only adopted at a period boundary (wrap or clear),
// so an in-flight period is never shortened or stretched by a write.
module tick_chan
  import clk_tick_gen_pkg::*;
#(
  parameter int          CNT_W   = 26,
  parameter int unsigned DEF_DIV = DEF_DIV_1HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             tick_o,
  output logic             sq_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             tick_q,   tick_d;
  logic             sq_q,     sq_d;

  ch_mode_e         mode;
  logic             wrap;
  logic [CNT_W:0]   hi_len;

  // Next-state logic: clear restarts, run counts/wraps, hold freezes.
  always_comb begin
    mode     = decode_mode(clear_i, en_i);
    wrap     = (cnt_q == (active_q - ONE));
    cnt_d    = cnt_q;
    active_d = active_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;
    hi_len   = '0;

    // Writes land in the shadow regardless of en; they surface at the next
    // boundary.
    shadow_d = ld_i ? ld_val_i : shadow_q;

    case (mode)
      CH_CLEAR: begin
        cnt_d    = '0;
        // A write in the same cycle as clear takes effect immediately.
        active_d = ld_i ? ld_val_i : shadow_q;
        // Count 0 always lies in the high half of the square wave.
        sq_d     = 1'b1;
      end
      CH_RUN: begin
        if (wrap) begin
          cnt_d    = '0;
          tick_d   = 1'b1;
          active_d = shadow_q;
        end else begin
          cnt_d    = cnt_q + ONE;
        end
        // High for the first ceil(active/2) counts; extra bit keeps
        // active+1 from overflowing at the top of the range.
        hi_len = ({1'b0, active_d} + ONE_X) >> 1;
        sq_d   = ({1'b0, cnt_d} < hi_len);
      end
      default: begin
        // Hold: counter, divisor and square wave keep their values.
      end
    endcase
  end

  // Channel state register with asynchronous return to the default divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= RST_DIV;
      shadow_q <= RST_DIV;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel clock-enable generator. Each channel produces a one-cycle
// tick per divisor period and a ~50% square wave, both as enables on clk.
// A single write port programs the per-channel divisors; bad writes are
// dropped and flagged with a one-cycle cfg_err pulse.
module clk_tick_gen
  import clk_tick_gen_pkg::*;
#(
  parameter int          CNT_W   = 26,
  parameter int          NUM_CH  = 2,
  parameter int unsigned DEF_DIV = DEF_DIV_1HZ,
  localparam int         SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              div_we_i,
  input  logic [SEL_W-1:0]  div_sel_i,
  input  logic [CNT_W-1:0]  div_val_i,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  logic              sel_ok;
  logic              val_ok;
  logic              accept;
  logic [NUM_CH-1:0] ld;
  logic              cfg_err_q, cfg_err_d;

  // Write decode: a write is taken only for a non-zero divisor aimed at an
  // existing channel; anything else raises cfg_err.
  always_comb begin
    sel_ok    = (int'(div_sel_i) < NUM_CH);
    val_ok    = (div_val_i != '0);
    accept    = div_we_i && sel_ok && val_ok;
    cfg_err_d = div_we_i && !accept;
    ld        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ld[i] = accept && (div_sel_i == SEL_W'(i));
    end
  end

  // Registered error pulse, one cycle per rejected write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err_o = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en_i),
      .clear_i  (clear_i),
      .ld_i     (ld[g]),
      .ld_val_i (div_val_i),
      .tick_o   (tick_o[g]),
      .sq_o     (sq_o[g])
    );
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen at CNT_W=8, NUM_CH=2, DEF_DIV=4.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_clk_tick_gen;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 2;

  // Clock and reset
  logic             clk;
  logic             reset;
  logic             en;
  logic             clear;
  logic             div_we;
  logic [0:0]       div_sel;
  logic [CNT_W-1:0] div_val;
  logic             cfg_err;
  logic [1:0]       tick;
  logic [1:0]       sq;

  int n_checks;
  int n_fail;

  clk_tick_gen #(
    .CNT_W   (CNT_W),
    .NUM_CH  (NUM_CH),
    .DEF_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en),
    .clear_i   (clear),
    .div_we_i  (div_we),
    .div_sel_i (div_sel),
    .div_val_i (div_val),
    .cfg_err_o (cfg_err),
    .tick_o    (tick),
    .sq_o      (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b0;
    clear   = 1'b0;
    div_we  = 1'b0;
    div_sel = 1'b0;
    div_val = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cfg_err, tick, sq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {cfg_err, tick, sq});
    end
  endtask

  task automatic test_basic();
    logic [1:0] et, es;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      et = (e % 4 == 0) ? 2'b11 : 2'b00;
      es = ((e % 4 == 0) || (e % 4 == 1)) ? 2'b11 : 2'b00;
      n_checks++;
      if (tick !== et) begin
        n_fail++;
        $display("FAIL basic_tick edge %0d: got %b want %b", e, tick, et);
      end
      n_checks++;
      if (sq !== es) begin
        n_fail++;
        $display("FAIL basic_sq edge %0d: got %b want %b", e, sq, es);
      end
    end
  endtask

  task automatic test_div_change();
    int t0[10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int t1[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    int s0[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    int s1[10] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    logic [1:0] et, es;
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 5; e++) step();
    // Counters now at 1 in their second period.
    div_we  = 1'b1;
    div_sel = 1'b1;
    div_val = 8'd3;
    for (int j = 1; j <= 10; j++) begin
      step();
      div_we = 1'b0;
      et = {t1[j-1][0], t0[j-1][0]};
      es = {s1[j-1][0], s0[j-1][0]};
      n_checks++;
      if (tick !== et) begin
        n_fail++;
        $display("FAIL divchg_tick step %0d: got %b want %b", j, tick, et);
      end
      n_checks++;
      if (sq !== es) begin
        n_fail++;
        $display("FAIL divchg_sq step %0d: got %b want %b", j, sq, es);
      end
    end
  endtask

  task automatic test_bad_write();
    logic [1:0] et;
    logic       ee;
    do_reset();
    en      = 1'b1;
    div_we  = 1'b1;
    div_sel = 1'b0;
    div_val = 8'd0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) begin
        div_sel = 1'b1;
      end else begin
        div_we = 1'b0;
      end
      ee = (e == 1) || (e == 2);
      et = (e % 4 == 0) ? 2'b11 : 2'b00;
      n_checks++;
      if (cfg_err !== ee) begin
        n_fail++;
        $display("FAIL bad_write_err edge %0d: got %b want %b", e, cfg_err, ee);
      end
      n_checks++;
      if (tick !== et) begin
        n_fail++;
        $display("FAIL bad_write_tick edge %0d: got %b want %b", e, tick, et);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 6; e++) step();
    // Counters at 2.
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if ({tick, sq} !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_outputs cycle %0d: got %b want 0000", k, {tick, sq});
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (tick !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_resume1: got %b want 00", tick);
    end
    step();
    n_checks++;
    if (tick !== 2'b11) begin
      n_fail++;
      $display("FAIL hold_resume2: got %b want 11", tick);
    end
  endtask

  task automatic test_clear_write();
    logic [1:0] et, es;
    do_reset();
    en = 1'b1;
    step();
    step();
    clear   = 1'b1;
    div_we  = 1'b1;
    div_sel = 1'b0;
    div_val = 8'd1;
    step();
    clear  = 1'b0;
    div_we = 1'b0;
    n_checks++;
    if ({cfg_err, tick, sq} !== 5'b00011) begin
      n_fail++;
      $display("FAIL clear_state: got %b want 00011", {cfg_err, tick, sq});
    end
    for (int j = 1; j <= 8; j++) begin
      step();
      et = {(j % 4 == 0), 1'b1};
      es = {((j % 4 == 0) || (j % 4 == 1)), 1'b1};
      n_checks++;
      if (tick !== et) begin
        n_fail++;
        $display("FAIL clear_tick step %0d: got %b want %b", j, tick, et);
      end
      n_checks++;
      if (sq !== es) begin
        n_fail++;
        $display("FAIL clear_sq step %0d: got %b want %b", j, sq, es);
      end
    end
    // Disabling must drop the div=1 tick while sq holds.
    en = 1'b0;
    step();
    n_checks++;
    if ({tick, sq} !== 4'b0011) begin
      n_fail++;
      $display("FAIL div1_en_off: got %b want 0011", {tick, sq});
    end
  endtask

  task automatic test_async_reset();
    logic et;
    do_reset();
    en      = 1'b1;
    div_we  = 1'b1;
    div_sel = 1'b0;
    div_val = 8'd7;
    step();
    div_we = 1'b0;
    n_checks++;
    if (sq !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_sq: got %b want 11", sq);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cfg_err, tick, sq} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 00000", {cfg_err, tick, sq});
    end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      et = (e % 4 == 0);
      n_checks++;
      if (tick[0] !== et) begin
        n_fail++;
        $display("FAIL post_reset_tick edge %0d: got %b want %b", e, tick[0], et);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_div_change();
    test_bad_write();
    test_enable_hold();
    test_clear_write();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
